// File: rtl/datapath.sv
// ============================================================================
// Module   : datapath
// Brief    : 8-bit accumulator datapath for a simple microcoded CPU.
//            Holds PC, IR, a 32x8 RAM with asynchronous read, accumulator A
//            and an add/subtract ALU. All sequencing comes from an external
//            controller; opcode and A status flags are returned to it.
//            Optional macro DATAPATH_RAM_RESET_EN: when defined, Reset also
//            clears every RAM word; otherwise RAM powers up undefined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PCload,
    input  logic              JMPmux,
    input  logic              IRload,
    input  logic              Meminst,
    input  logic              MemWr,
    input  logic              Aload,
    input  logic              Sub,
    input  logic [1:0]        Asel,
    output logic              Aeq0,
    output logic              Apos,
    output logic [OPC_W-1:0]  IR,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] RAMAddress,
    output logic [ADDR_W-1:0] lower5bits_IR,
    output logic [ADDR_W-1:0] outputFromPC
);

    localparam int DEPTH = 2 ** ADDR_W;

    // A input mux encoding
    localparam logic [1:0] ASEL_ALU  = 2'd0;
    localparam logic [1:0] ASEL_IN   = 2'd1;
    localparam logic [1:0] ASEL_RAM  = 2'd2;
    localparam logic [1:0] ASEL_ZERO = 2'd3;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] a_next;
    logic [ADDR_W-1:0] pc_next;

    // Address mux and asynchronous RAM read; a same-cycle write is not
    // visible here until after the edge.
    always_comb begin
        RAMAddress = Meminst ? instr[ADDR_W-1:0] : pc;
        rd         = mem[RAMAddress];
    end

    // Modulo-2^DATA_W add/subtract; carry and borrow are dropped.
    always_comb begin
        alu_res = Sub ? (acc - rd) : (acc + rd);
    end

    // Next-value selection for A and PC.
    always_comb begin
        a_next = '0;
        case (Asel)
            ASEL_ALU:  a_next = alu_res;
            ASEL_IN:   a_next = data_in;
            ASEL_RAM:  a_next = rd;
            ASEL_ZERO: a_next = '0;
            default:   a_next = '0;
        endcase
        pc_next = JMPmux ? instr[ADDR_W-1:0] : (pc + ADDR_W'(1));
    end

    // Architectural registers; each enable is independent and samples
    // pre-edge values, so jump-and-fetch or store-and-load can coexist.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc   <= '0;
            pc    <= '0;
            instr <= '0;
        end else begin
            if (Aload)  acc   <= a_next;
            if (IRload) instr <= rd;
            if (PCload) pc    <= pc_next;
        end
    end

`ifdef DATAPATH_RAM_RESET_EN
    // RAM write of the pre-edge A; Reset wipes the whole array.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWr) begin
            mem[RAMAddress] <= acc;
        end
    end
`else
    // RAM write of the pre-edge A; contents survive Reset.
    always_ff @(posedge Clock) begin
        if (MemWr) begin
            mem[RAMAddress] <= acc;
        end
    end
`endif

    // Status and observation outputs, straight from the registers.
    always_comb begin
        data_out      = acc;
        Aeq0          = (acc == '0);
        Apos          = ~acc[DATA_W-1];
        IR            = instr[DATA_W-1:ADDR_W];
        lower5bits_IR = instr[ADDR_W-1:0];
        outputFromPC  = pc;
    end

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ============================================================================
// Module   : tb_datapath
// Brief    : Self-checking bench for datapath: directed walk-through with
//            literal expectations, then randomized control sequences checked
//            every cycle against a behavioural model of the datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       PCload = 1'b0, JMPmux = 1'b0, IRload = 1'b0, Meminst = 1'b0;
    logic       MemWr = 1'b0, Aload = 1'b0, Sub = 1'b0;
    logic [1:0] Asel = 2'd0;
    logic [7:0] data_in = 8'd0;
    logic       Aeq0, Apos;
    logic [2:0] IR;
    logic [7:0] data_out;
    logic [4:0] RAMAddress, lower5bits_IR, outputFromPC;

    int n_cmp = 0;
    int n_err = 0;

    datapath dut (
        .Clock(Clock), .Reset(Reset), .PCload(PCload), .JMPmux(JMPmux),
        .IRload(IRload), .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload),
        .Sub(Sub), .Asel(Asel), .Aeq0(Aeq0), .Apos(Apos), .IR(IR),
        .data_in(data_in), .data_out(data_out), .RAMAddress(RAMAddress),
        .lower5bits_IR(lower5bits_IR), .outputFromPC(outputFromPC)
    );

    always #5 Clock = ~Clock;

    // ---------------- behavioural model (plain integers) ----------------
    int m_a   = 0;
    int m_pc  = 0;
    int m_ir  = 0;
    int m_ram [32];

    function automatic int addr_now();
        return Meminst ? (m_ir % 32) : m_pc;
    endfunction

    function automatic int rd_now();
        return m_ram[addr_now()];
    endfunction

    function automatic int a_choice();
        case (Asel)
            2'd0:    return Sub ? ((m_a - rd_now() + 256) % 256) : ((m_a + rd_now()) % 256);
            2'd1:    return int'(data_in);
            2'd2:    return rd_now();
            default: return 0;
        endcase
    endfunction

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_a  <= 0;
            m_pc <= 0;
            m_ir <= 0;
`ifdef DATAPATH_RAM_RESET_EN
            for (int i = 0; i < 32; i++) m_ram[i] <= 0;
`endif
        end else begin
            if (Aload)  m_a  <= a_choice();
            if (IRload) m_ir <= rd_now();
            if (PCload) m_pc <= JMPmux ? (m_ir % 32) : ((m_pc + 1) % 32);
            if (MemWr)  m_ram[addr_now()] <= m_a;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clock) begin
        logic [27:0] exp_v, act_v;
        exp_v = {8'(m_a), (m_a == 0), (m_a < 128), 3'(m_ir / 32), 5'(m_ir % 32),
                 5'(m_pc), 5'(addr_now())};
        act_v = {data_out, Aeq0, Apos, IR, lower5bits_IR, outputFromPC, RAMAddress};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL cycle_model t=%0t: got %h, expected %h (A,eq0,pos,op,ir5,pc,addr)",
                     $time, act_v, exp_v);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        PCload = 0; JMPmux = 0; IRload = 0; Meminst = 0;
        MemWr = 0; Aload = 0; Sub = 0; Asel = 2'd0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic load_a(input int v);
        data_in = 8'(v); Asel = 2'd1; Aload = 1; tick();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge Clock);
        #1 Reset = 0;
        chk("reset_data_out", data_out, 0);
        chk("reset_Aeq0", Aeq0, 1);
        chk("reset_Apos", Apos, 1);
        chk("reset_pc", outputFromPC, 0);
        chk("reset_ir", lower5bits_IR, 0);

        load_a(5);
        chk("load5_A", data_out, 5);
        chk("load5_Aeq0", Aeq0, 0);
        chk("load5_Apos", Apos, 1);

        Meminst = 1; MemWr = 1; tick();          // RAM[0] = 5
        Meminst = 1; Asel = 0; Aload = 1; tick();
        chk("add_1", data_out, 10);
        Meminst = 1; Asel = 0; Aload = 1; tick();
        chk("add_2", data_out, 15);
        Meminst = 1; Sub = 1; Asel = 0; Aload = 1; tick();
        chk("sub_1", data_out, 10);
        Meminst = 1; Sub = 1; Asel = 0; Aload = 1; tick();
        chk("sub_2", data_out, 5);

        Meminst = 1; IRload = 1; data_in = 8'd3; Asel = 2'd1; Aload = 1; tick();
        chk("ir_low", lower5bits_IR, 5);
        chk("ir_opc", IR, 0);
        chk("a_during_irload", data_out, 3);
        Meminst = 1; MemWr = 1; tick();          // RAM[5] = 3
        load_a(0);
        chk("a_zero_eq0", Aeq0, 1);
        Meminst = 1; Asel = 2'd2; Aload = 1; tick();
        chk("a_from_ram5", data_out, 3);

        JMPmux = 1; PCload = 1; tick();
        chk("jump_pc", outputFromPC, 5);
        PCload = 1; tick();
        chk("inc_pc", outputFromPC, 6);
        load_a(1);
        MemWr = 1; tick();                       // RAM[6] = 1
        Asel = 2'd3; Aload = 1; tick();
        chk("a_clear", data_out, 0);
        Asel = 2'd2; Aload = 1; tick();
        chk("a_from_ram6", data_out, 1);

        load_a(200);
        chk("a200_Apos", Apos, 0);
        MemWr = 1; tick();                       // RAM[6] = 200
        Meminst = 1; Asel = 2'd2; Aload = 1; tick();
        chk("meminst1_read", data_out, 3);
        Asel = 2'd2; Aload = 1; tick();
        chk("meminst0_read", data_out, 200);
        Meminst = 1; #1;
        chk("ramaddr_ir", RAMAddress, 5);
        Meminst = 0; #1;
        chk("ramaddr_pc", RAMAddress, 6);

        repeat (25) begin PCload = 1; tick(); end
        chk("pc_31", outputFromPC, 31);
        PCload = 1; tick();
        chk("pc_wrap", outputFromPC, 0);
        load_a(1);
        MemWr = 1; tick();                       // RAM[0] = 1
        Asel = 2'd3; Aload = 1; tick();
        Sub = 1; Asel = 2'd0; Aload = 1; tick();
        chk("borrow_A", data_out, 255);
        chk("borrow_Apos", Apos, 0);

        // asynchronous reset between edges
        PCload = 1; tick();
        #3 Reset = 1;
        #1;
        chk("async_rst_A", data_out, 0);
        chk("async_rst_pc", outputFromPC, 0);
        chk("async_rst_ir", lower5bits_IR, 0);
        chk("async_rst_Aeq0", Aeq0, 1);
        #2 Reset = 0;
        tick();

        // fill every RAM word while stepping PC (store old A, load new A)
        load_a($urandom_range(0, 255));
        for (int k = 0; k < 32; k++) begin
            MemWr = 1; PCload = 1; Aload = 1; Asel = 2'd1;
            data_in = 8'($urandom_range(0, 255));
            tick();
        end

        // randomized control sequences
        for (int c = 0; c < 1500; c++) begin
            PCload  = 1'($urandom_range(0, 1));
            JMPmux  = 1'($urandom_range(0, 1));
            IRload  = 1'($urandom_range(0, 1));
            Meminst = 1'($urandom_range(0, 1));
            MemWr   = 1'($urandom_range(0, 1));
            Aload   = 1'($urandom_range(0, 1));
            Sub     = 1'($urandom_range(0, 1));
            Asel    = 2'($urandom_range(0, 3));
            data_in = 8'($urandom_range(0, 255));
            @(posedge Clock);
            #1;
        end
        idle();
        @(negedge Clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
